// File: rtl/jtag_register_master.sv
`default_nettype none
// ============================================================================
//  Module      : jtag_register_master
//  Description : Host-side JTAG initiator. Converts one parallel register
//                read/write request into a TAP bit sequence (IR scan selecting
//                {write, addr}, then a DR scan of REGISTER_SIZE bits) and
//                returns the DR bits captured from TDO.
//  Revision    : 1.0 - initial release
// ============================================================================
module jtag_register_master #(
  parameter int REGISTER_SIZE       = 32,
  parameter int NUMBER_OF_REGISTERS = 31,
  parameter int ADDR_WIDTH          = 5,
  parameter int CLK_DIV             = 4
) (
  input  logic                     iMAIN_CLK,
  input  logic                     iRESET,
  input  logic                     iREQ_VALID,
  output logic                     oREQ_READY,
  input  logic                     iREQ_WRITE,
  input  logic [ADDR_WIDTH-1:0]    iREQ_ADDR,
  input  logic [REGISTER_SIZE-1:0] iREQ_WDATA,
  output logic                     oRSP_VALID,
  output logic [REGISTER_SIZE-1:0] oRSP_RDATA,
  output logic                     oRSP_ERROR,
  output logic                     oTCK,
  output logic                     oTMS,
  output logic                     oTDI,
  input  logic                     iTDO
);

  // Divider counts one full TCK bit: CLK_DIV cycles low, then CLK_DIV high.
  localparam int c_DIV_W = (2 * CLK_DIV > 2) ? $clog2(2 * CLK_DIV) : 1;
  localparam int c_BIT_W = $clog2(REGISTER_SIZE + ADDR_WIDTH + 8);

  localparam logic [c_DIV_W-1:0] c_DIV_ONE  = c_DIV_W'(1);
  localparam logic [c_DIV_W-1:0] c_DIV_HIGH = c_DIV_W'(CLK_DIV - 1);
  localparam logic [c_DIV_W-1:0] c_DIV_LOW  = c_DIV_W'(2 * CLK_DIV - 1);

  // Bit indices inside each scan phase.
  localparam logic [c_BIT_W-1:0] c_BIT_ONE         = c_BIT_W'(1);
  localparam logic [c_BIT_W-1:0] c_RST_LAST        = c_BIT_W'(5);
  localparam logic [c_BIT_W-1:0] c_IR_SHIFT_FIRST  = c_BIT_W'(4);
  localparam logic [c_BIT_W-1:0] c_IR_SHIFT_LAST   = c_BIT_W'(ADDR_WIDTH + 4);
  localparam logic [c_BIT_W-1:0] c_IR_UPDATE       = c_BIT_W'(ADDR_WIDTH + 5);
  localparam logic [c_BIT_W-1:0] c_IR_LAST         = c_BIT_W'(ADDR_WIDTH + 6);
  localparam logic [c_BIT_W-1:0] c_DR_SHIFT_FIRST  = c_BIT_W'(3);
  localparam logic [c_BIT_W-1:0] c_DR_SHIFT_LAST   = c_BIT_W'(REGISTER_SIZE + 2);
  localparam logic [c_BIT_W-1:0] c_DR_UPDATE       = c_BIT_W'(REGISTER_SIZE + 3);
  localparam logic [c_BIT_W-1:0] c_DR_LAST         = c_BIT_W'(REGISTER_SIZE + 4);

  localparam logic [ADDR_WIDTH:0] c_NUM_REGS = (ADDR_WIDTH + 1)'(NUMBER_OF_REGISTERS);

  typedef enum logic [2:0] {
    TAP_RST = 3'd0,
    IDLE    = 3'd1,
    IR_SCAN = 3'd2,
    DR_SCAN = 3'd3,
    RESP    = 3'd4
  } stateT;

  stateT                   r_state;
  logic [c_DIV_W-1:0]      r_divCnt;
  logic [c_BIT_W-1:0]      r_bitCnt;
  logic [ADDR_WIDTH:0]     r_irShift;
  logic [REGISTER_SIZE-1:0] r_drShift;
  logic [REGISTER_SIZE-1:0] r_rdShift;
  logic                    r_tdoMeta;
  logic                    r_tdoSync;

  stateT                   w_nextState;
  logic [c_BIT_W-1:0]      w_nextIdx;
  logic                    w_nextTms;
  logic                    w_nextIrShift;
  logic                    w_nextDrShift;
  logic                    w_sampleBit;

  // Two-flop synchroniser for the externally clocked TDO line.
  always_ff @(posedge iMAIN_CLK or posedge iRESET) begin
    if (iRESET) begin
      r_tdoMeta <= 1'b0;
      r_tdoSync <= 1'b0;
    end else begin
      r_tdoMeta <= iTDO;
      r_tdoSync <= r_tdoMeta;
    end
  end

  // Work out which bit follows the current one and what TMS/TDI it carries.
  always_comb begin
    w_nextState   = r_state;
    w_nextIdx     = r_bitCnt + c_BIT_ONE;
    w_nextTms     = 1'b0;
    w_nextIrShift = 1'b0;
    w_nextDrShift = 1'b0;
    w_sampleBit   = (r_state == DR_SCAN) &&
                    (r_bitCnt >= c_DR_SHIFT_FIRST) && (r_bitCnt <= c_DR_SHIFT_LAST);

    case (r_state)
      TAP_RST: if (r_bitCnt == c_RST_LAST) begin w_nextState = IDLE;    w_nextIdx = '0; end
      IR_SCAN: if (r_bitCnt == c_IR_LAST)  begin w_nextState = DR_SCAN; w_nextIdx = '0; end
      DR_SCAN: if (r_bitCnt == c_DR_LAST)  begin w_nextState = RESP;    w_nextIdx = '0; end
      default: ;
    endcase

    case (w_nextState)
      TAP_RST: w_nextTms = (w_nextIdx != c_RST_LAST);
      IR_SCAN: begin
        // Select-DR, Select-IR, ..., Exit1-IR on last shift, Update-IR.
        w_nextTms     = (w_nextIdx <= c_BIT_ONE) || (w_nextIdx == c_IR_SHIFT_LAST) ||
                        (w_nextIdx == c_IR_UPDATE);
        w_nextIrShift = (w_nextIdx >= c_IR_SHIFT_FIRST) && (w_nextIdx <= c_IR_SHIFT_LAST);
      end
      DR_SCAN: begin
        // Select-DR, ..., Exit1-DR on last shift, Update-DR.
        w_nextTms     = (w_nextIdx == '0) || (w_nextIdx == c_DR_SHIFT_LAST) ||
                        (w_nextIdx == c_DR_UPDATE);
        w_nextDrShift = (w_nextIdx >= c_DR_SHIFT_FIRST) && (w_nextIdx <= c_DR_SHIFT_LAST);
      end
      default: ;
    endcase
  end

  // Main sequencer: request handshake, TCK generation, scan shifting, response.
  always_ff @(posedge iMAIN_CLK or posedge iRESET) begin
    if (iRESET) begin
      r_state    <= TAP_RST;
      r_divCnt   <= '0;
      r_bitCnt   <= '0;
      r_irShift  <= '0;
      r_drShift  <= '0;
      r_rdShift  <= '0;
      oTCK       <= 1'b0;
      oTMS       <= 1'b1;
      oTDI       <= 1'b0;
      oREQ_READY <= 1'b0;
      oRSP_VALID <= 1'b0;
      oRSP_RDATA <= '0;
      oRSP_ERROR <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          oTCK <= 1'b0;
          oTMS <= 1'b0;
          oTDI <= 1'b0;
          if (iREQ_VALID && oREQ_READY) begin
            oREQ_READY <= 1'b0;
            r_divCnt   <= '0;
            r_bitCnt   <= '0;
            if ({1'b0, iREQ_ADDR} >= c_NUM_REGS) begin
              // Bad address never touches the chain.
              r_state    <= RESP;
              oRSP_VALID <= 1'b1;
              oRSP_ERROR <= 1'b1;
              oRSP_RDATA <= '0;
            end else begin
              // First IR bit (TMS=1 to Select-DR) starts on this edge.
              r_state   <= IR_SCAN;
              oTMS      <= 1'b1;
              r_irShift <= {iREQ_WRITE, iREQ_ADDR};
              r_drShift <= iREQ_WRITE ? iREQ_WDATA : '0;
            end
          end
        end

        RESP: begin
          oRSP_VALID <= 1'b0;
          oRSP_ERROR <= 1'b0;
          oREQ_READY <= 1'b1;
          r_state    <= IDLE;
        end

        default: begin
          if (r_divCnt == c_DIV_HIGH) begin
            oTCK     <= 1'b1;
            r_divCnt <= r_divCnt + c_DIV_ONE;
            if (w_sampleBit) r_rdShift <= {r_tdoSync, r_rdShift[REGISTER_SIZE-1:1]};
          end else if (r_divCnt == c_DIV_LOW) begin
            oTCK     <= 1'b0;
            r_divCnt <= '0;
            r_state  <= w_nextState;
            r_bitCnt <= w_nextIdx;
            oTMS     <= w_nextTms;
            if (w_nextIrShift) begin
              oTDI      <= r_irShift[0];
              r_irShift <= r_irShift >> 1;
            end else if (w_nextDrShift) begin
              oTDI      <= r_drShift[0];
              r_drShift <= r_drShift >> 1;
            end else begin
              oTDI <= 1'b0;
            end
            if (w_nextState == IDLE) oREQ_READY <= 1'b1;
            if (w_nextState == RESP) begin
              oRSP_VALID <= 1'b1;
              oRSP_ERROR <= 1'b0;
              oRSP_RDATA <= r_rdShift;
            end
          end else begin
            r_divCnt <= r_divCnt + c_DIV_ONE;
          end
        end
      endcase
    end
  end

endmodule
`default_nettype wire
